// File: rtl/ripple_c_nbit_pkg.sv
// ----------------------------------------------------------------------------
// ripple_c_nbit_pkg
// Shared datapath constants for the ripple-carry adder slice.
//   ADDER_W : default operand/sum width of ripple_c_nbit
// ----------------------------------------------------------------------------
package ripple_c_nbit_pkg;

   localparam int unsigned ADDER_W = 16;

endpackage : ripple_c_nbit_pkg

// File: rtl/ripple_c_nbit_full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// One-bit combinational full-adder cell, the building block of the ripple chain.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of a, b, cin)
// ----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/ripple_c_nbit.sv
// ----------------------------------------------------------------------------
// ripple_c_nbit
// N-bit ripple-carry adder (chain of full_adder cells) with a registered
// output stage; one cycle latency, one result per cycle.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   A, B      : unsigned operands [N-1:0]
//   Cin       : carry into bit 0
//   in_valid  : capture A/B/Cin on this edge
//   Sum       : registered sum [N-1:0]
//   Cout      : registered carry out of bit N-1
//   out_valid : Sum/Cout were updated by the previous edge
// ----------------------------------------------------------------------------
module ripple_c_nbit
   import ripple_c_nbit_pkg::*;
#(
   parameter int unsigned N = ADDER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   input  logic         in_valid,
   output logic [N-1:0] Sum,
   output logic         Cout,
   output logic         out_valid
);

   logic [N-1:0] s;
   logic         carry_out;

   // Ripple chain. Each cell owns its carry-out net and the next cell reads
   // it from the neighbouring generate block, so the carry moves strictly
   // cell to cell without a self-referencing carry vector.
   for (genvar i = 0; i < int'(N); i++) begin : g_bit
      logic cin;
      logic cout;

      if (i == 0) begin : g_first
         assign cin = Cin;
      end else begin : g_next
         assign cin = g_bit[i-1].cout;
      end

      full_adder u_fa (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (cin),
         .s    (s[i]),
         .cout (cout)
      );
   end

   assign carry_out = g_bit[N-1].cout;

   // Output register: reset wins, results hold while in_valid is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         Sum       <= '0;
         Cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            Sum  <= s;
            Cout <= carry_out;
         end
      end
   end

endmodule : ripple_c_nbit

// File: tb/tb_ripple_c_nbit.sv
// ----------------------------------------------------------------------------
// tb_ripple_c_nbit
// Directed and random checks of ripple_c_nbit at N=16, N=8 and N=1.
// ----------------------------------------------------------------------------
module tb_ripple_c_nbit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;

   logic [15:0] a16, b16, sum16;
   logic        cin16, cout16, ov16;
   logic [7:0]  a8, b8, sum8;
   logic        cin8, cout8, ov8;
   logic [0:0]  a1, b1, sum1;
   logic        cin1, cout1, ov1;

   int unsigned tests = 0;
   int unsigned fails = 0;

   always #5 clk = ~clk;

   ripple_c_nbit #(.N(16)) u_dut16 (
      .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(cin16), .in_valid(in_valid),
      .Sum(sum16), .Cout(cout16), .out_valid(ov16)
   );

   ripple_c_nbit #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .in_valid(in_valid),
      .Sum(sum8), .Cout(cout8), .out_valid(ov8)
   );

   ripple_c_nbit #(.N(1)) u_dut1 (
      .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .in_valid(in_valid),
      .Sum(sum1), .Cout(cout1), .out_valid(ov1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive the N=16 inputs, then step past the next rising edge.
   task automatic drive16(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic v);
      a16      = a;
      b16      = b;
      cin16    = cin;
      in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic check16(input string tag, input logic [15:0] s_exp,
                          input logic c_exp, input logic v_exp);
      chk({tag, ".sum"},  32'(sum16),  32'(s_exp));
      chk({tag, ".cout"}, 32'(cout16), 32'(c_exp));
      chk({tag, ".ov"},   32'(ov16),   32'(v_exp));
   endtask

   logic [16:0] e16;
   logic [8:0]  e8;
   logic [1:0]  e1;
   logic        v;

   initial begin
      rst = 1'b1; in_valid = 1'b0;
      a16 = '0; b16 = '0; cin16 = 1'b0;
      a8  = '0; b8  = '0; cin8  = 1'b0;
      a1  = '0; b1  = '0; cin1  = 1'b0;

      // 1. reset held two cycles, then first capture
      drive16(16'd0, 16'd0, 1'b0, 1'b0);
      check16("rst_c1", 16'd0, 1'b0, 1'b0);
      drive16(16'd0, 16'd0, 1'b0, 1'b0);
      check16("rst_c2", 16'd0, 1'b0, 1'b0);
      rst = 1'b0;
      drive16(16'd12, 16'd238, 1'b0, 1'b1);
      check16("first", 16'd250, 1'b0, 1'b1);

      // 2. back-to-back sweep, A in {12,13}, B 238..244, Cin 0 then 1
      for (int c = 0; c < 2; c++) begin
         for (int a = 12; a <= 13; a++) begin
            for (int b = 238; b <= 244; b++) begin
               drive16(16'(a), 16'(b), 1'(c), 1'b1);
               check16("sweep", 16'(a + b + c), 1'b0, 1'b1);
            end
         end
      end
      drive16(16'd13, 16'd244, 1'b1, 1'b1);
      check16("sweep_258", 16'd258, 1'b0, 1'b1);

      // 3. carry-out and full ripple
      drive16(16'hFFFF, 16'h0000, 1'b1, 1'b1);
      check16("ffff_p1", 16'h0000, 1'b1, 1'b1);
      drive16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      check16("ffff_ffff_p1", 16'hFFFF, 1'b1, 1'b1);
      drive16(16'h8000, 16'h8000, 1'b0, 1'b1);
      check16("msb_msb", 16'h0000, 1'b1, 1'b1);

      // 4. hold while in_valid is low
      drive16(16'd100, 16'd200, 1'b0, 1'b1);
      check16("hold_cap", 16'd300, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive16(16'd1, 16'd1, 1'b0, 1'b0);
         check16("hold", 16'd300, 1'b0, 1'b0);
      end

      // 5. reset on the same edge as a valid input
      rst = 1'b1;
      drive16(16'd5, 16'd6, 1'b0, 1'b1);
      check16("rst_mid", 16'd0, 1'b0, 1'b0);
      rst = 1'b0;
      drive16(16'd5, 16'd6, 1'b0, 1'b1);
      check16("post_rst", 16'd11, 1'b0, 1'b1);

      // 6. random regression on all three widths with a reference model
      rst = 1'b1;
      drive16(16'd0, 16'd0, 1'b0, 1'b0);
      rst = 1'b0;
      e16 = '0; e8 = '0; e1 = '0;
      for (int k = 0; k < 1000; k++) begin
         v    = ($urandom_range(0, 3) != 0);
         a8   = 8'($urandom);
         b8   = 8'($urandom);
         cin8 = 1'($urandom);
         a1   = 1'($urandom);
         b1   = 1'($urandom);
         cin1 = 1'($urandom);
         if (v) begin
            e8 = 9'(a8) + 9'(b8) + 9'(cin8);
            e1 = 2'(a1) + 2'(b1) + 2'(cin1);
         end
         a16   = 16'($urandom);
         b16   = 16'($urandom);
         cin16 = 1'($urandom);
         if (v) e16 = 17'(a16) + 17'(b16) + 17'(cin16);
         drive16(a16, b16, cin16, v);
         chk("rnd16", 32'({cout16, sum16}), 32'(e16));
         chk("rnd8",  32'({cout8, sum8}),   32'(e8));
         chk("rnd1",  32'({cout1, sum1}),   32'(e1));
         chk("rnd_ov", 32'({ov16, ov8, ov1}), 32'({v, v, v}));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_ripple_c_nbit

// File: doc/ripple_c_nbit.md
Name: ripple_c_nbit

Overview:
Parameterised N-bit ripple-carry adder with a registered output stage.
- Computes Sum = A + B + Cin as a combinational chain of N full-adder cells.
- Captures the result in output registers on the rising clock edge.
- Used as a generic datapath adder; the default width is 16 bits.

Parameters:
N, 16, operand and sum width in bits; legal range N >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
A  input  N  operand A, unsigned.
B  input  N  operand B, unsigned.
Cin  input  1  carry into bit 0.
in_valid  input  1  qualifies A/B/Cin for capture this cycle.
Sum  output  N  registered sum bits [N-1:0].
Cout  output  1  registered carry out of bit N-1.
out_valid  output  1  high for one cycle when Sum/Cout were updated by the previous edge.

Behaviour:
- Combinational core is a ripple chain of full-adder cells:
  - c[0] = Cin
  - s[i] = A[i] ^ B[i] ^ c[i]
  - c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i])
  - core Cout = c[N]
- Arithmetic identity: {Cout, Sum} == A + B + Cin, computed as an (N+1)-bit unsigned result.
- No carry-lookahead or other restructuring is permitted. The carry must propagate cell-to-cell (bit-serial ripple).
- Register stage, on every rising clk edge:
  - rst=1: Sum <= 0, Cout <= 0, out_valid <= 0. Reset has priority over in_valid.
  - rst=0, in_valid=1: Sum <= s, Cout <= c[N], out_valid <= 1.
  - rst=0, in_valid=0: Sum and Cout hold their previous values; out_valid <= 0.
- Latency: exactly 1 clock from a captured input to valid output.
- Throughput: one result per cycle; back-to-back in_valid is supported.
- No backpressure; the output is never stalled.
- Boundary: all-ones + all-ones + 1 gives Sum = all-ones and Cout = 1. The wrap-around modulo 2^N is reported only through Cout.
- No signed-overflow flag. Callers interpret operands as unsigned.
- Reset mid-stream: the in-flight result is discarded, and the first post-reset capture needs in_valid.
- Inputs are sampled only at the clock edge. Combinational glitches on A/B/Cin between edges have no effect.
- N=1 degenerates to a single registered full adder; this configuration must elaborate and function.

Decomposition:
- No shared package is required. If the team keeps a datapath constants package, the default width constant ADDER_W = 16 goes there.
- One sub-module: full_adder. It is purely combinational, with ports a, b, cin, s, cout.
- full_adder is instantiated N times in a generate loop. An internal carry vector c[N:0] chains the cells.
- The register stage lives in ripple_c_nbit itself.

Test Plan:
1. N=16, rst held 2 cycles -> Sum=0, Cout=0, out_valid=0. Then rst=0, in_valid=1, A=12, B=238, Cin=0 -> next cycle Sum=250, Cout=0, out_valid=1.
2. Sweep with Cin=0 then Cin=1: A in {12,13}, B from 238 to 244, one vector per cycle with in_valid=1. Each result, one cycle later, equals A+B+Cin. For example, A=13, B=244, Cin=1 -> Sum=258, Cout=0.
3. Carry-out and full ripple:
   - A=16'hFFFF, B=0, Cin=1 -> Sum=0, Cout=1.
   - A=16'hFFFF, B=16'hFFFF, Cin=1 -> Sum=16'hFFFF, Cout=1.
   - A=16'h8000, B=16'h8000, Cin=0 -> Sum=0, Cout=1.
4. Hold: capture A=100, B=200, Cin=0 (Sum=300). Then drive in_valid=0 with A=1, B=1 for 3 cycles -> Sum stays 300, out_valid=0.
5. Reset mid-stream: in_valid=1 with A=5, B=6, and rst=1 on the same edge -> Sum=0, Cout=0, out_valid=0. The next edge with rst=0 and in_valid=1 produces 11.
6. Random regression for N=1, N=8 and N=16: at least 1000 random vectors, scoreboard compares {Cout, Sum} against A+B+Cin, delayed by 1 cycle.
